pe_kl_config_ctrl: RTL and testbench
====================================

// Module: pe_kl_config_ctrl
// PURPOSE
//  Sequencer that programs one key/lock pair into the DummyPE key-lock config
//  logic and gates computation on the match result.
//  - Accepts a {lock, key} descriptor over a valid/ready handshake.
//  - Writes the lock: kl_type=0 plus a 1-cycle set pulse.
//  - Presents the key (kl_type=1), samples the PE match flag kl_valid, and retries on mismatch.
//  - Enables the calculation datapath (calc_en) only while the PE stays matched.
// PARAMETERS
//  BUS_WIDTH   8  width of lock/key words and of the kl_data bus
//  MATCH_WAIT  2  cycles the key is held before kl_valid is sampled (>=2; 1 for PE key register + 1 settle)
//  MAX_RETRY   2  extra lock/key attempts after a first mismatch before declaring failure
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-low
//  cfg_valid  in   1          descriptor valid
//  cfg_ready  out  1          descriptor accepted when cfg_valid & cfg_ready
//  cfg_lock   in   BUS_WIDTH  lock word
//  cfg_key    in   BUS_WIDTH  key word
//  disarm     in   1          leave ARMED/FAIL and return to IDLE
//  kl_type    out  1          to PE: 0 = lock word, 1 = key word
//  kl_data    out  BUS_WIDTH  to PE: key/lock data
//  pe_set     out  1          to PE: lock CSR write strobe
//  kl_valid   in   1          from PE: key matches lock
//  calc_en    out  1          datapath enable
//  done       out  1          1-cycle pulse at end of a configuration attempt sequence
//  status_ok  out  1          result qualifier: 1 = matched, 0 = failed; held until next accept
//  busy       out  1          high in LOCK or KEY
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//  - state=IDLE; kl_type=0, kl_data=0, pe_set=0, calc_en=0, done=0, status_ok=0, busy=0.
//  - Captured lock/key registers and retry counter cleared.
//  - Reset mid-operation aborts immediately; no partial pe_set is issued.
//  States:
//  - IDLE:
//    - cfg_ready=1; outputs at reset values.
//    - On accept: capture cfg_lock/cfg_key, clear retry counter -> LOCK.
//  - LOCK (exactly 1 cycle): kl_type=0, kl_data=lock_r, pe_set=1 -> KEY; wait counter cleared.
//  - KEY (MATCH_WAIT cycles): kl_type=1, kl_data=key_r, pe_set=0.
//    - kl_valid is sampled only in the last KEY cycle; kl_valid in earlier cycles is ignored.
//    - kl_valid=1 -> ARMED; done=1 and status_ok=1 in the first ARMED cycle.
//    - kl_valid=0, retry<MAX_RETRY -> retry++, back to LOCK (lock is rewritten).
//    - kl_valid=0, retry==MAX_RETRY -> FAIL; done=1 and status_ok=0 in the first FAIL cycle.
//  - ARMED:
//    - kl_type=1, kl_data=key_r held; calc_en = kl_valid (combinational gate).
//    - disarm=1 -> IDLE; disarm has priority over a kl_valid drop in the same cycle.
//    - kl_valid=0 (no disarm) -> FAIL next cycle, status_ok<=0, no done pulse.
//    - cfg_ready=0.
//  - FAIL:
//    - cfg_ready=1; kl_type=0, kl_data=0, pe_set=0, calc_en=0.
//    - Accept -> LOCK with new descriptor; accept has priority over disarm.
//    - disarm alone -> IDLE.
//  Handshake and status:
//  - cfg_ready depends on state only, never on cfg_valid.
//  - A descriptor offered while busy is not consumed and must be held by the source.
//  - status_ok holds its value through IDLE; it is cleared on the next accept.
//  Timing:
//  - Latency from accept cycle T to done is 2+MATCH_WAIT cycles per attempt.
//    At defaults: done at T+4; each retry adds 1+MATCH_WAIT cycles.
//  Sizing:
//  - Retry counter width = $clog2(MAX_RETRY+1); no wrap is possible.
//  - MAX_RETRY=0 means a single attempt.
//  - Elaboration error if MATCH_WAIT<2.
// TESTING
//  1. BUS_WIDTH=8, lock=0xA5, key=0xA5, PE model matches; accept at T
//     -> pe_set at T+1, kl_type=1 at T+2..T+3, done & status_ok=1 at T+4, calc_en=1.
//  2. lock=0x3C, key=0x00, PE never matches
//     -> exactly 3 pe_set pulses at T+1, T+4, T+7;
//     -> FAIL with done=1, status_ok=0 at T+10; calc_en never high.
//  3. Mismatch on first attempt, match on second
//     -> 2 pe_set pulses; done & status_ok=1 at T+7.
//  4. ARMED, force kl_valid=0
//     -> calc_en low same cycle, FAIL next cycle, no done.
//  5. Same scenario with disarm=1 in that cycle -> IDLE, not FAIL.
//  6. rst=0 in the 2nd KEY cycle
//     -> next cycle IDLE, all outputs at reset values.
//  7. New cfg_valid held from T+1 while busy
//     -> cfg_ready=0 until state returns to IDLE/FAIL.
//     -> After disarm, accepted in the first IDLE cycle with the held data.

Source files
------------

// File: rtl/pe_kl_config_ctrl_if.sv
// Bundle of descriptor handshake, disarm control and DummyPE key-lock signals.
// Handshake: a descriptor moves when cfg_valid & cfg_ready are both high at a rising
// clk edge; cfg_ready depends on controller state only and the source holds its data until then.
interface pe_kl_config_ctrl_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [BUS_WIDTH-1:0] cfg_lock;
    logic [BUS_WIDTH-1:0] cfg_key;
    logic                 disarm;
    logic                 kl_type;
    logic [BUS_WIDTH-1:0] kl_data;
    logic                 pe_set;
    logic                 kl_valid;
    logic                 calc_en;
    logic                 done;
    logic                 status_ok;
    logic                 busy;

    modport slave (
        input  cfg_valid, cfg_lock, cfg_key, disarm, kl_valid,
        output cfg_ready, kl_type, kl_data, pe_set, calc_en, done, status_ok, busy
    );

    modport master (
        output cfg_valid, cfg_lock, cfg_key, disarm, kl_valid,
        input  cfg_ready, kl_type, kl_data, pe_set, calc_en, done, status_ok, busy
    );
endinterface

// File: rtl/pe_kl_config_ctrl.sv
// Programs one lock/key pair into the DummyPE key-lock logic, retries on mismatch,
// and enables the calculation datapath only while the PE reports a match.
module pe_kl_config_ctrl #(
    parameter int BUS_WIDTH  = 8,
    parameter int MATCH_WAIT = 2,
    parameter int MAX_RETRY  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    pe_kl_config_ctrl_if.slave     bus,
    output logic [2:0]             o_dbg_state
);
    // MAX_RETRY=0 would give a zero-width counter; keep one bit, it simply never counts.
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int WAIT_W  = $clog2(MATCH_WAIT);
    localparam logic [WAIT_W-1:0]  LAST_WAIT = WAIT_W'(MATCH_WAIT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    generate
        if (MATCH_WAIT < 2) begin : g_bad_match_wait
            $error("pe_kl_config_ctrl: MATCH_WAIT must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOCK  = 3'd1,
        S_KEY   = 3'd2,
        S_ARMED = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BUS_WIDTH-1:0] r_lock;
    logic [BUS_WIDTH-1:0] r_key;
    logic [RETRY_W-1:0]   r_retry;
    logic [WAIT_W-1:0]    r_wait;
    logic                 r_done;
    logic                 r_status_ok;

    logic                 w_accept;
    logic                 w_last_key;
    logic                 w_cfg_ready;
    logic                 w_kl_type;
    logic [BUS_WIDTH-1:0] w_kl_data;
    logic                 w_pe_set;
    logic                 w_calc_en;
    logic                 w_busy;

    assign w_accept   = bus.cfg_valid && (r_state == S_IDLE || r_state == S_FAIL);
    assign w_last_key = (r_state == S_KEY) && (r_wait == LAST_WAIT);

    always_comb begin
        w_next      = r_state;
        w_cfg_ready = 1'b0;
        w_kl_type   = 1'b0;
        w_kl_data   = '0;
        w_pe_set    = 1'b0;
        w_calc_en   = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cfg_ready = 1'b1;
                if (w_accept) w_next = S_LOCK;
            end
            S_LOCK: begin
                w_kl_data = r_lock;
                w_pe_set  = 1'b1;
                w_busy    = 1'b1;
                w_next    = S_KEY;
            end
            S_KEY: begin
                w_kl_type = 1'b1;
                w_kl_data = r_key;
                w_busy    = 1'b1;
                if (w_last_key) begin
                    if (bus.kl_valid)          w_next = S_ARMED;
                    else if (r_retry < RETRY_MAX) w_next = S_LOCK;
                    else                       w_next = S_FAIL;
                end
            end
            S_ARMED: begin
                w_kl_type = 1'b1;
                w_kl_data = r_key;
                w_calc_en = bus.kl_valid;
                // Disarm wins over a simultaneous match loss.
                if (bus.disarm)         w_next = S_IDLE;
                else if (!bus.kl_valid) w_next = S_FAIL;
            end
            S_FAIL: begin
                w_cfg_ready = 1'b1;
                if (w_accept)        w_next = S_LOCK;
                else if (bus.disarm) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_lock      <= '0;
            r_key       <= '0;
            r_retry     <= '0;
            r_wait      <= '0;
            r_done      <= 1'b0;
            r_status_ok <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_last_key && (w_next != S_LOCK);
            r_wait  <= (r_state == S_KEY) ? r_wait + WAIT_W'(1) : '0;
            if (w_accept) begin
                r_lock      <= bus.cfg_lock;
                r_key       <= bus.cfg_key;
                r_retry     <= '0;
                r_status_ok <= 1'b0;
            end else begin
                if (w_last_key && !bus.kl_valid && (r_retry < RETRY_MAX))
                    r_retry <= r_retry + RETRY_W'(1);
                if (w_last_key && bus.kl_valid)
                    r_status_ok <= 1'b1;
                else if (w_next == S_FAIL)
                    r_status_ok <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.kl_type   = w_kl_type;
    assign bus.kl_data   = w_kl_data;
    assign bus.pe_set    = w_pe_set;
    assign bus.calc_en   = w_calc_en;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.status_ok = r_status_ok;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_pe_kl_config_ctrl.sv
// Self-checking bench: expected per-cycle outputs come from an attempt/timeline model
// derived from the lock/key/retry rules; PE match flags are scheduled per attempt.
module tb_pe_kl_config_ctrl;
    localparam int BW   = 8;
    localparam int MW   = 2;
    localparam int MAXR = 2;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         checks;
    int         failures;

    pe_kl_config_ctrl_if #(.BUS_WIDTH(BW)) bus ();

    pe_kl_config_ctrl #(
        .BUS_WIDTH  (BW),
        .MATCH_WAIT (MW),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {cfg_ready, kl_type, pe_set, calc_en, done, status_ok, busy, kl_data}
    function automatic logic [14:0] pack_out();
        return {bus.cfg_ready, bus.kl_type, bus.pe_set, bus.calc_en,
                bus.done, bus.status_ok, bus.busy, bus.kl_data};
    endfunction

    // Called just after a rising edge: offers a descriptor in this cycle and follows the
    // whole attempt sequence. m = number of leading attempts on which the PE mismatches.
    task automatic drive_config(input logic [7:0] lk, input logic [7:0] ky, input int m,
                                input bit dis_t, input bit hold,
                                input logic [7:0] nl, input logic [7:0] nk,
                                output bit matched, output int n_set);
        int n, e, a, p;
        logic [14:0] exp_v, act_v;
        matched = (m <= MAXR);
        n = matched ? m + 1 : MAXR + 1;
        e = (2 + MW) + (n - 1) * (1 + MW);
        n_set = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_lock  = lk;
        bus.cfg_key   = ky;
        bus.disarm    = dis_t;
        bus.kl_valid  = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: got %b want 1", bus.cfg_ready);
        end
        for (int o = 1; o <= e; o++) begin
            @(posedge clk); #1;
            bus.disarm = 1'b0;
            if (hold) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_lock  = nl;
                bus.cfg_key   = nk;
            end else begin
                bus.cfg_valid = 1'b0;
                bus.cfg_lock  = 8'($urandom);
                bus.cfg_key   = 8'($urandom);
            end
            if (o < e) begin
                a = (o - 1) / (1 + MW);
                p = (o - 1) % (1 + MW);
                if (p == 0) begin
                    exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lk};
                    bus.kl_valid = 1'($urandom_range(0, 1));
                end else begin
                    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ky};
                    bus.kl_valid = (p == MW) ? (a >= m) : 1'($urandom_range(0, 1));
                end
            end else begin
                bus.kl_valid = matched;
                exp_v = {!matched, matched, 1'b0, matched, 1'b1, matched, 1'b0,
                         matched ? ky : 8'h00};
            end
            #1;
            act_v = pack_out();
            if (bus.pe_set === 1'b1) n_set++;
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL seq_offset_%0d: got %h want %h (lock=%h key=%h m=%0d)",
                         o, act_v, exp_v, lk, ky, m);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_lock  = '0;
        bus.cfg_key   = '0;
        bus.disarm    = 1'b0;
        bus.kl_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pack_out() !== 15'h4000) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 4000", pack_out());
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pack_out() !== 15'h4000) begin
            failures++;
            $display("FAIL idle_after_reset: got %h want 4000", pack_out());
        end
    endtask

    task automatic test_match();
        bit ok; int ns;
        @(posedge clk); #1;
        drive_config(8'hA5, 8'hA5, 0, 1'b0, 1'b0, 8'h00, 8'h00, ok, ns);
        checks++;
        if (ns != 1) begin
            failures++;
            $display("FAIL match_pe_set_count: got %0d want 1", ns);
        end
        @(posedge clk); #1;
        bus.disarm = 1'b1;
        @(posedge clk); #1;
        bus.disarm = 1'b0;
        #1;
        checks++;
        if (pack_out() !== {1'b1, 6'b000010, 8'h00}) begin
            failures++;
            $display("FAIL match_disarm_idle: got %h want %h", pack_out(), {1'b1, 6'b000010, 8'h00});
        end
    endtask

    task automatic test_fail();
        bit ok; int ns;
        @(posedge clk); #1;
        drive_config(8'h3C, 8'h00, 3, 1'b0, 1'b0, 8'h00, 8'h00, ok, ns);
        checks++;
        if (ns != MAXR + 1) begin
            failures++;
            $display("FAIL fail_pe_set_count: got %0d want %0d", ns, MAXR + 1);
        end
        @(posedge clk); #1;
        bus.kl_valid = 1'b1;
        #1;
        checks++;
        if (pack_out() !== 15'h4000) begin
            failures++;
            $display("FAIL fail_state_hold: got %h want 4000", pack_out());
        end
        @(posedge clk); #1;
        bus.disarm = 1'b1;
        @(posedge clk); #1;
        bus.disarm = 1'b0;
        #1;
        checks++;
        if (pack_out() !== 15'h4000) begin
            failures++;
            $display("FAIL fail_disarm_idle: got %h want 4000", pack_out());
        end
    endtask

    task automatic test_retry();
        bit ok; int ns;
        @(posedge clk); #1;
        drive_config(8'($urandom), 8'($urandom), 1, 1'b0, 1'b0, 8'h00, 8'h00, ok, ns);
        checks++;
        if (ns != 2) begin
            failures++;
            $display("FAIL retry_pe_set_count: got %0d want 2", ns);
        end
        @(posedge clk); #1;
        bus.disarm = 1'b1;
        @(posedge clk); #1;
        bus.disarm = 1'b0;
    endtask

    task automatic test_armed_drop();
        bit ok; int ns;
        logic [7:0] ky;
        ky = 8'($urandom);
        @(posedge clk); #1;
        drive_config(8'($urandom), ky, 0, 1'b0, 1'b0, 8'h00, 8'h00, ok, ns);
        @(posedge clk); #1;
        bus.kl_valid = 1'b0;
        #1;
        checks++;
        if (pack_out() !== {1'b0, 6'b100010, ky}) begin
            failures++;
            $display("FAIL armed_drop_same_cycle: got %h want %h", pack_out(), {1'b0, 6'b100010, ky});
        end
        @(posedge clk); #1;
        bus.kl_valid = 1'b1;
        #1;
        checks++;
        if (pack_out() !== 15'h4000) begin
            failures++;
            $display("FAIL armed_drop_fail: got %h want 4000", pack_out());
        end
        @(posedge clk); #1;
        bus.disarm = 1'b1;
        @(posedge clk); #1;
        bus.disarm = 1'b0;
    endtask

    task automatic test_armed_disarm();
        bit ok; int ns;
        logic [7:0] ky;
        ky = 8'($urandom);
        @(posedge clk); #1;
        drive_config(8'($urandom), ky, 0, 1'b0, 1'b0, 8'h00, 8'h00, ok, ns);
        @(posedge clk); #1;
        bus.kl_valid = 1'b0;
        bus.disarm   = 1'b1;
        #1;
        checks++;
        if (bus.calc_en !== 1'b0) begin
            failures++;
            $display("FAIL disarm_calc_en: got %b want 0", bus.calc_en);
        end
        @(posedge clk); #1;
        bus.disarm = 1'b0;
        #1;
        checks++;
        if (pack_out() !== {1'b1, 6'b000010, 8'h00}) begin
            failures++;
            $display("FAIL disarm_priority_idle: got %h want %h", pack_out(), {1'b1, 6'b000010, 8'h00});
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.cfg_valid = 1'b1;
        bus.cfg_lock  = 8'($urandom);
        bus.cfg_key   = 8'($urandom);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.kl_type !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_in_key: got busy=%b kl_type=%b want 1 1", bus.busy, bus.kl_type);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (pack_out() !== 15'h4000) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h want 4000", pack_out());
        end
        @(posedge clk); #1;
        checks++;
        if (pack_out() !== 15'h4000) begin
            failures++;
            $display("FAIL reset_mid_no_set: got %h want 4000", pack_out());
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int ns;
        logic [7:0] bl, bk;
        bl = 8'($urandom);
        bk = 8'($urandom);
        @(posedge clk); #1;
        drive_config(8'($urandom), 8'($urandom), 0, 1'b0, 1'b1, bl, bk, ok, ns);
        @(posedge clk); #1;
        bus.disarm = 1'b1;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_armed_not_ready: got %b want 0", bus.cfg_ready);
        end
        @(posedge clk); #1;
        drive_config(bl, bk, 0, 1'b0, 1'b0, 8'h00, 8'h00, ok, ns);
        @(posedge clk); #1;
        bus.disarm = 1'b1;
        @(posedge clk); #1;
        bus.disarm = 1'b0;
    endtask

    task automatic test_random();
        bit ok, prev_fail;
        int ns, m;
        prev_fail = 1'b0;
        for (int i = 0; i < 12; i++) begin
            m = $urandom_range(0, 3);
            @(posedge clk); #1;
            drive_config(8'($urandom), 8'($urandom), m,
                         prev_fail ? 1'($urandom_range(0, 1)) : 1'b0,
                         1'b0, 8'h00, 8'h00, ok, ns);
            checks++;
            if (ns != (ok ? m + 1 : MAXR + 1)) begin
                failures++;
                $display("FAIL rand_pe_set_count: got %0d want %0d", ns, ok ? m + 1 : MAXR + 1);
            end
            if (ok) begin
                @(posedge clk); #1;
                bus.disarm = 1'b1;
                @(posedge clk); #1;
                bus.disarm = 1'b0;
                #1;
                checks++;
                if (pack_out() !== {1'b1, 6'b000010, 8'h00}) begin
                    failures++;
                    $display("FAIL rand_idle_status_held: got %h want %h", pack_out(), {1'b1, 6'b000010, 8'h00});
                end
                prev_fail = 1'b0;
            end else begin
                prev_fail = 1'b1;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_match();
        test_fail();
        test_retry();
        test_armed_drop();
        test_armed_disarm();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
